// File: rtl/save_ctrl_pkg.sv
// Shared definitions for the save-point controller: state encoding, save-point
// placement, respawn defaults and the hit-box helper.
package save_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ALIVE   = 2'd0,
        ST_SAVING  = 2'd1,
        ST_DEAD    = 2'd2,
        ST_RESPAWN = 2'd3
    } save_state_e;

    localparam int unsigned NUM_SAVES = 4;
    localparam int unsigned CNT_W     = 25;
    localparam int unsigned BOX_SIZE  = 32;

    localparam logic [9:0] HIT_MARGIN_X = 10'd3;
    localparam logic [9:0] HIT_MARGIN_Y = 10'd7;

    localparam logic [9:0] DEFAULT_X = 10'd32;
    localparam logic [9:0] DEFAULT_Y = 10'd400;

    // Index 0 is the rightmost entry. Save 3 sits near the origin so its
    // lower hit bounds clamp to zero.
    localparam logic [NUM_SAVES-1:0][9:0] SAVE_X = {10'd2, 10'd320, 10'd300, 10'd95};
    localparam logic [NUM_SAVES-1:0][9:0] SAVE_Y = {10'd4, 10'd210, 10'd200, 10'd320};

    // Widened to 11 bits so the upper bound cannot wrap near the screen edge.
    function automatic logic in_box(input logic [9:0] kx, input logic [9:0] ky,
                                    input logic [9:0] sx, input logic [9:0] sy);
        logic [10:0] lo_x;
        logic [10:0] hi_x;
        logic [10:0] lo_y;
        logic [10:0] hi_y;
        lo_x = (sx >= HIT_MARGIN_X) ? {1'b0, sx - HIT_MARGIN_X} : 11'd0;
        lo_y = (sy >= HIT_MARGIN_Y) ? {1'b0, sy - HIT_MARGIN_Y} : 11'd0;
        hi_x = {1'b0, sx} + 11'(BOX_SIZE) + {1'b0, HIT_MARGIN_X};
        hi_y = {1'b0, sy} + 11'(BOX_SIZE) + {1'b0, HIT_MARGIN_Y};
        return ({1'b0, kx} >= lo_x) && ({1'b0, kx} < hi_x) &&
               ({1'b0, ky} >= lo_y) && ({1'b0, ky} < hi_y);
    endfunction

endpackage

// File: rtl/save_ctrl_hit.sv
// Combinational kid-versus-save-point box test; one hit bit per save point.
module save_hit
    import save_ctrl_pkg::*;
(
    input  logic [9:0]           kid_x,
    input  logic [9:0]           kid_y,
    output logic [NUM_SAVES-1:0] hit
);

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_SAVES; i++) begin
            hit[i] = in_box(kid_x, kid_y, SAVE_X[i], SAVE_Y[i]);
        end
    end

endmodule

// File: rtl/save_ctrl.sv
// Save-point controller: records triggered saves, flashes an acknowledgement,
// handles death, the minimum dead time and respawn at the last save.
module save_ctrl
    import save_ctrl_pkg::*;
#(
    parameter int unsigned FLASH_CYC    = 25000000,
    parameter int unsigned MIN_DEAD_CYC = 1000000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [9:0]           kid_x,
    input  logic [9:0]           kid_y,
    input  logic                 shoot,
    input  logic                 kid_dead,
    input  logic                 restart,
    output logic [NUM_SAVES-1:0] saved_mask,
    output logic                 save_flash,
    output logic [9:0]           respawn_x,
    output logic [9:0]           respawn_y,
    output logic                 respawn_load,
    output logic [1:0]           state
);

    save_state_e          state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_SAVES-1:0] mask_q, mask_d;
    logic [9:0]           rx_q, rx_d;
    logic [9:0]           ry_q, ry_d;
    logic                 shoot_q, shoot_d;
    logic                 restart_q, restart_d;
    logic                 armed_q, armed_d;

    logic [NUM_SAVES-1:0] hit;
    logic [1:0]           sel;
    logic                 shoot_rise;
    logic                 restart_rise;

    save_hit u_hit (
        .kid_x (kid_x),
        .kid_y (kid_y),
        .hit   (hit)
    );

    // armed_q stays low for the first cycle after reset so a key already held
    // then is captured into the edge register without counting as a press.
    assign shoot_rise   = armed_q & shoot   & ~shoot_q;
    assign restart_rise = armed_q & restart & ~restart_q;

    always_comb begin
        sel = 2'd0;
        for (int i = NUM_SAVES - 1; i >= 0; i--) begin
            if (hit[i]) sel = 2'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        rx_d      = rx_q;
        ry_d      = ry_q;
        shoot_d   = shoot;
        restart_d = restart;
        armed_d   = 1'b1;
        case (state_q)
            ST_ALIVE: begin
                if (kid_dead) begin
                    state_d = ST_DEAD;
                end else if (restart_rise) begin
                    state_d = ST_RESPAWN;
                end else if (shoot_rise && (|hit)) begin
                    mask_d      = mask_q | (NUM_SAVES'(1) << sel);
                    rx_d        = SAVE_X[sel];
                    ry_d        = SAVE_Y[sel];
                    state_d     = ST_SAVING;
                end
            end
            ST_SAVING: begin
                if (kid_dead) begin
                    state_d = ST_DEAD;
                end else if (restart_rise) begin
                    state_d = ST_RESPAWN;
                end else if (cnt_q >= CNT_W'(FLASH_CYC - 1)) begin
                    state_d = ST_ALIVE;
                end
            end
            ST_DEAD: begin
                if (restart_rise && (cnt_q >= CNT_W'(MIN_DEAD_CYC))) begin
                    state_d = ST_RESPAWN;
                end
            end
            ST_RESPAWN: begin
                state_d = ST_ALIVE;
            end
            default: begin
                state_d = ST_ALIVE;
            end
        endcase

        // One counter serves both flash and dead timing: restart on every
        // state change, otherwise count up and hold at the top.
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ALIVE;
            cnt_q     <= '0;
            mask_q    <= '0;
            rx_q      <= DEFAULT_X;
            ry_q      <= DEFAULT_Y;
            shoot_q   <= 1'b0;
            restart_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mask_q    <= mask_d;
            rx_q      <= rx_d;
            ry_q      <= ry_d;
            shoot_q   <= shoot_d;
            restart_q <= restart_d;
            armed_q   <= armed_d;
        end
    end

    assign saved_mask   = mask_q;
    assign save_flash   = (state_q == ST_SAVING);
    assign respawn_load = (state_q == ST_RESPAWN);
    assign respawn_x    = rx_q;
    assign respawn_y    = ry_q;
    assign state        = state_q;

endmodule

// File: tb/tb_save_ctrl.sv
// Directed bench for save_ctrl with short flash and dead timing.
module tb_save_ctrl;

    logic       clk;
    logic       rst;
    logic [9:0] kid_x;
    logic [9:0] kid_y;
    logic       shoot;
    logic       kid_dead;
    logic       restart;
    logic [3:0] saved_mask;
    logic       save_flash;
    logic [9:0] respawn_x;
    logic [9:0] respawn_y;
    logic       respawn_load;
    logic [1:0] state;

    int checks;
    int failures;
    int flash_cnt;

    save_ctrl #(
        .FLASH_CYC    (10),
        .MIN_DEAD_CYC (20)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .kid_x        (kid_x),
        .kid_y        (kid_y),
        .shoot        (shoot),
        .kid_dead     (kid_dead),
        .restart      (restart),
        .saved_mask   (saved_mask),
        .save_flash   (save_flash),
        .respawn_x    (respawn_x),
        .respawn_y    (respawn_y),
        .respawn_load (respawn_load),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [1:0] st, input logic [3:0] mask,
                             input logic flash, input logic load,
                             input logic [9:0] rx, input logic [9:0] ry);
        check({tag, "_state"}, 32'(state), 32'(st));
        check({tag, "_mask"},  32'(saved_mask), 32'(mask));
        check({tag, "_flash"}, 32'(save_flash), 32'(flash));
        check({tag, "_load"},  32'(respawn_load), 32'(load));
        check({tag, "_rx"},    32'(respawn_x), 32'(rx));
        check({tag, "_ry"},    32'(respawn_y), 32'(ry));
    endtask

    task automatic wait_alive(input string tag);
        for (int k = 0; k < 40 && state != 2'd0; k++) step();
        check({tag, "_back_alive"}, 32'(state), 32'd0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1; kid_x = 10'd500; kid_y = 10'd500;
        shoot = 1'b0; kid_dead = 1'b0; restart = 1'b0;
        step(); step();
        check_all("reset", 2'd0, 4'b0000, 1'b0, 1'b0, 10'd32, 10'd400);
        rst = 1'b0;
        step();

        // Shoot with no save point in reach does nothing.
        shoot = 1'b1; step(); shoot = 1'b0; step();
        check_all("no_hit", 2'd0, 4'b0000, 1'b0, 1'b0, 10'd32, 10'd400);

        // Save 0 exactly on its origin; flash lasts exactly 10 cycles.
        kid_x = 10'd95; kid_y = 10'd320;
        shoot = 1'b1; step(); shoot = 1'b0;
        check_all("save0", 2'd1, 4'b0001, 1'b1, 1'b0, 10'd95, 10'd320);
        flash_cnt = 1;
        for (int k = 0; k < 30 && save_flash; k++) begin
            step();
            if (save_flash) flash_cnt++;
        end
        check("flash_len", 32'(flash_cnt), 32'd10);
        check("after_flash_state", 32'(state), 32'd0);

        // Overlap of saves 1 and 2: lowest index wins.
        kid_x = 10'd320; kid_y = 10'd210;
        shoot = 1'b1; step(); shoot = 1'b0;
        check_all("overlap", 2'd1, 4'b0011, 1'b1, 1'b0, 10'd300, 10'd200);
        step();
        // Shoot during SAVING is ignored, even over a fresh save point.
        kid_x = 10'd0; kid_y = 10'd0;
        shoot = 1'b1; step(); shoot = 1'b0; step();
        check("saving_shoot_mask", 32'(saved_mask), 32'b0011);
        check("saving_shoot_rx", 32'(respawn_x), 32'd300);
        wait_alive("overlap");

        // Save 3 near the origin: lower bounds clamp, so (0,0) hits.
        shoot = 1'b1; step(); shoot = 1'b0;
        check_all("clamp", 2'd1, 4'b1011, 1'b1, 1'b0, 10'd2, 10'd4);
        wait_alive("clamp");

        // Death and save on the same edge: death wins, save discarded.
        kid_x = 10'd340; kid_y = 10'd230;
        shoot = 1'b1; kid_dead = 1'b1; step();
        shoot = 1'b0; kid_dead = 1'b0;
        check_all("dead_vs_save", 2'd2, 4'b1011, 1'b0, 1'b0, 10'd2, 10'd4);

        // Restart while dead: too early at count 5, accepted at count 25.
        for (int k = 0; k < 5; k++) step();
        restart = 1'b1; step(); restart = 1'b0;
        check("early_restart_state", 32'(state), 32'd2);
        check("early_restart_load", 32'(respawn_load), 32'd0);
        step();
        for (int k = 0; k < 18; k++) step();
        check("still_dead", 32'(state), 32'd2);
        restart = 1'b1; step(); restart = 1'b0;
        check_all("respawn", 2'd3, 4'b1011, 1'b0, 1'b1, 10'd2, 10'd4);
        kid_dead = 1'b1; step(); kid_dead = 1'b0;
        check("respawn_one_cycle_state", 32'(state), 32'd0);
        check("respawn_one_cycle_load", 32'(respawn_load), 32'd0);
        step();

        // Voluntary restart from ALIVE is immediate.
        restart = 1'b1; step(); restart = 1'b0;
        check("vol_restart_state", 32'(state), 32'd3);
        check("vol_restart_load", 32'(respawn_load), 32'd1);
        step();
        check("vol_restart_alive", 32'(state), 32'd0);

        // Reset in the middle of SAVING.
        kid_x = 10'd95; kid_y = 10'd320;
        shoot = 1'b1; step(); shoot = 1'b0;
        check("resave0_rx", 32'(respawn_x), 32'd95);
        step(); step(); step();
        rst = 1'b1; step();
        check_all("mid_save_rst", 2'd0, 4'b0000, 1'b0, 1'b0, 10'd32, 10'd400);

        // Shoot held through reset release must not trigger a save.
        shoot = 1'b1; step(); rst = 1'b0;
        step(); step(); step();
        check("held_mask", 32'(saved_mask), 32'd0);
        check("held_state", 32'(state), 32'd0);
        shoot = 1'b0; step();
        shoot = 1'b1; step(); shoot = 1'b0;
        check("repress_mask", 32'(saved_mask), 32'b0001);
        check("repress_state", 32'(state), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
